// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port block RAM with read-valid routing.
// Optional macro RAM_ARB_FIXED_PRIO_EN: fixed priority (port 0 wins ties) instead of round-robin.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rd_valid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rd_valid1,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    logic                  pick1;
    logic                  launch0;
    logic                  launch1;
    logic [RD_LATENCY-1:0] rd_pipe0;
    logic [RD_LATENCY-1:0] rd_pipe1;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb pick1 = req1 & ~req0;
`else
    logic last_gnt;

    // Port 1 wins a tie only when port 0 held the previous grant.
    always_comb pick1 = req1 & (~req0 | ~last_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && (req0 | req1)) begin
            last_gnt <= pick1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state       <= ACCESS;
                        ram_en      <= 1'b1;
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        ram_we      <= pick1 ? we1 : we0;
                        ram_addr    <= pick1 ? addr1 : addr0;
                        ram_wr_data <= pick1 ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    state  <= IDLE;
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read is launched in its ACCESS cycle; the grant identifies the issuing port.
    always_comb begin
        launch0 = gnt0 & ~ram_we;
        launch1 = gnt1 & ~ram_we;
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_pipe0 <= '0;
                    rd_pipe1 <= '0;
                end else begin
                    rd_pipe0 <= launch0;
                    rd_pipe1 <= launch1;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_pipe0 <= '0;
                    rd_pipe1 <= '0;
                end else begin
                    rd_pipe0 <= {rd_pipe0[RD_LATENCY-2:0], launch0};
                    rd_pipe1 <= {rd_pipe1[RD_LATENCY-2:0], launch1};
                end
            end
        end
    endgenerate

    always_comb begin
        rd_valid0 = rd_pipe0[RD_LATENCY-1];
        rd_valid1 = rd_pipe1[RD_LATENCY-1];
        rd_data   = ram_rd_data;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (read latency 1 and 2) share stimulus and are
// checked every cycle against a grant-timestamp reference model with a shadow memory.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;

    logic       g0_a, g1_a, rv0_a, rv1_a, en_a, we_a;
    logic [4:0] addr_a;
    logic [7:0] wd_a, rdd_a, rr_a;
    logic       g0_b, g1_b, rv0_b, rv1_b, en_b, we_b;
    logic [4:0] addr_b;
    logic [7:0] wd_b, rdd_b, rr_b;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(g0_a), .rd_valid0(rv0_a),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(g1_a), .rd_valid1(rv1_a),
        .rd_data(rdd_a), .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a),
        .ram_wr_data(wd_a), .ram_rd_data(rr_a)
    );

    ram_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LATENCY(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(g0_b), .rd_valid0(rv0_b),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(g1_b), .rd_valid1(rv1_b),
        .rd_data(rdd_b), .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b),
        .ram_wr_data(wd_b), .ram_rd_data(rr_b)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 5) ? 8'h3C : 8'((i * 37) + 11);
    endfunction

    // Block RAM stand-ins: latency 1 (no output register) and latency 2 (output register).
    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    logic [7:0] rp_a;
    logic [7:0] rp_b [2];
    logic       mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
            mem_init_done <= 1'b1;
        end else begin
            if (en_a) begin
                if (we_a) mem_a[addr_a] <= wd_a;
                rp_a <= mem_a[addr_a];
            end
            if (en_b) begin
                if (we_b) mem_b[addr_b] <= wd_b;
                rp_b[0] <= mem_b[addr_b];
            end
            rp_b[1] <= rp_b[0];
        end
    end

    assign rr_a = rp_a;
    assign rr_b = rp_b[1];

    int total = 0;
    int bad   = 0;
    int now   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, now);
        end
    endtask

    // Reference model: a grant is possible when at least two edges have passed since the
    // previous one; reads are scored by (grant cycle + latency).
    typedef struct {
        int         c;
        logic       p;
        logic [7:0] d;
    } rd_t;

    rd_t        rdq[$];
    int         last_g = -10;
    logic       last_p = 1'b1;
    logic       e_g0 = 1'b0, e_g1 = 1'b0, e_en = 1'b0, e_we = 1'b0;
    logic [4:0] e_addr = '0;
    logic [7:0] e_wd = '0;
    logic [7:0] shadow [32];

    task automatic model_edge();
        logic       p;
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        now++;
        if (rst) begin
            e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
            last_p = 1'b1;
            last_g = -10;
            rdq.delete();
        end else begin
            e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0;
            if ((req0 || req1) && (now - last_g >= 2)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                p = req0 ? 1'b0 : 1'b1;
`else
                p = (req0 && req1) ? !last_p : req1;
`endif
                w = p ? we1 : we0;
                a = p ? addr1 : addr0;
                d = p ? wdata1 : wdata0;
                e_en = 1; e_g0 = !p; e_g1 = p; e_we = w; e_addr = a; e_wd = d;
                last_p = p;
                last_g = now;
                if (w) shadow[a] = d;
                else   rdq.push_back('{now, p, shadow[a]});
            end
        end
        while (rdq.size() > 0 && rdq[0].c + 3 < now) void'(rdq.pop_front());
    endtask

    task automatic check_rd(input int lat, input string pfx, input logic rv0, input logic rv1,
                            input logic [7:0] rdata);
        logic       x0 = 0, x1 = 0;
        logic [7:0] xd = '0;
        foreach (rdq[i]) begin
            if (rdq[i].c + lat == now) begin
                if (rdq[i].p) x1 = 1; else x0 = 1;
                xd = rdq[i].d;
            end
        end
        check_eq({pfx, ".rd_valid0"}, rv0, x0);
        check_eq({pfx, ".rd_valid1"}, rv1, x1);
        if (x0 || x1) check_eq({pfx, ".rd_data"}, rdata, xd);
    endtask

    task automatic check_all();
        check_eq("a.gnt0", g0_a, e_g0);
        check_eq("a.gnt1", g1_a, e_g1);
        check_eq("a.ram_en", en_a, e_en);
        check_eq("a.ram_we", we_a, e_we);
        check_eq("a.ram_addr", addr_a, e_addr);
        check_eq("a.ram_wr_data", wd_a, e_wd);
        check_eq("b.gnt0", g0_b, e_g0);
        check_eq("b.gnt1", g1_b, e_g1);
        check_eq("b.ram_en", en_b, e_en);
        check_eq("b.ram_we", we_b, e_we);
        check_eq("b.ram_addr", addr_b, e_addr);
        check_eq("b.ram_wr_data", wd_b, e_wd);
        check_rd(1, "a", rv0_a, rv1_a, rdd_a);
        check_rd(2, "b", rv0_b, rv1_b, rdd_b);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raise a request, wait (bounded) for its grant, then drop it in the grant cycle.
    task automatic issue(input logic p, input logic w, input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        do begin
            step();
            n++;
        end while (!(p ? g1_a : g0_a) && n < 10);
        check_eq("issue_grant", p ? g1_a : g0_a, 1);
        if (p) req1 = 0; else req0 = 0;
    endtask

    initial begin
        int seq[$];
        logic saw1;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);

        rst = 1;
        idle(3);
        rst = 0;
        idle(2);

        issue(0, 1, 5'd3, 8'hA5);
        idle(3);

        issue(1, 0, 5'd3, 8'h00);
        step();
        check_eq("tp_rv1_lat1", rv1_a, 1);
        check_eq("tp_rdata_lat1", rdd_a, 8'hA5);
        check_eq("tp_rv0_lat1", rv0_a, 0);
        step();
        check_eq("tp_rv1_lat2", rv1_b, 1);
        check_eq("tp_rdata_lat2", rdd_b, 8'hA5);
        idle(3);

        // Both ports requesting continuously.
        req0 = 1; we0 = 0; addr0 = 5'd1; wdata0 = 8'h00;
        req1 = 1; we1 = 1; addr1 = 5'd2; wdata1 = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            step();
            if (g0_a) seq.push_back(0);
            if (g1_a) seq.push_back(1);
        end
        check_eq("both_grant_count", seq.size(), 6);
        foreach (seq[i]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            check_eq("both_grant_order", seq[i], 0);
`else
            check_eq("both_grant_order", seq[i], i % 2);
`endif
        end
        req0 = 0;
        saw1 = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (g1_a) saw1 = 1;
        end
        check_eq("drop_req0_gnt1", saw1, 1);
        req1 = 0;
        idle(3);

        issue(0, 0, 5'd5, 8'h00);
        step();
        check_eq("lat1_rv0", rv0_a, 1);
        check_eq("lat1_data_3c", rdd_a, 8'h3C);
        step();
        check_eq("lat2_rv0", rv0_b, 1);
        check_eq("lat2_data_3c", rdd_b, 8'h3C);
        idle(3);

        // Reset sampled at the edge ending the read's grant cycle.
        issue(0, 0, 5'd5, 8'h00);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_rv0_a", rv0_a, 0);
            check_eq("rst_rv0_b", rv0_b, 0);
            check_eq("rst_ram_en", en_a, 0);
            check_eq("rst_gnt0", g0_a, 0);
        end
        rst = 0;
        issue(1, 0, 5'd5, 8'h00);
        step();
        check_eq("post_rst_rv1", rv1_a, 1);
        check_eq("post_rst_data", rdd_a, 8'h3C);
        idle(2);

        // Reset one cycle later: the latency-2 read is still in flight and must be dropped.
        issue(0, 0, 5'd5, 8'h00);
        step();
        rst = 1;
        step();
        check_eq("inflight_rv0_b", rv0_b, 0);
        rst = 0;
        idle(2);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1; we0 = 1'($urandom); addr0 = 5'($urandom_range(0, 7)); wdata0 = 8'($urandom);
                end
            end else if (g0_a) begin
                if ($urandom_range(0, 1) == 0) req0 = 0;
                else begin we0 = 1'($urandom); addr0 = 5'($urandom_range(0, 7)); wdata0 = 8'($urandom); end
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1; we1 = 1'($urandom); addr1 = 5'($urandom_range(0, 7)); wdata1 = 8'($urandom);
                end
            end else if (g1_a) begin
                if ($urandom_range(0, 1) == 0) req1 = 0;
                else begin we1 = 1'($urandom); addr1 = 5'($urandom_range(0, 7)); wdata1 = 8'($urandom); end
            end
        end
        rst = 0; req0 = 0; req1 = 0;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter and sequencer for the 32x8 single-port block RAM IP (ena/wea/addra/dina/douta).
- Sits between two client engines (e.g. a ram_rw-style test writer and a readback/checker) and the RAM instance.
- Serialises their accesses with round-robin arbitration and routes read-data valid back to the issuing requester.

Parameters:
ADDR_W, 5, RAM address width (matches addra [4:0])
DATA_W, 8, RAM data width (matches dina/douta [7:0])
RD_LATENCY, 1, cycles from ram_en (read) to valid douta; legal 1..3 (1 = no output register, 2 = primitive output register)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 access request, held until gnt0
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  one-cycle grant pulse to requester 0
rd_valid0  output  1  read data valid for requester 0
req1/we1/addr1/wdata1  input  1/1/ADDR_W/DATA_W  same as port 0, requester 1
gnt1  output  1  one-cycle grant pulse to requester 1
rd_valid1  output  1  read data valid for requester 1
rd_data  output  DATA_W  shared read data, qualified by rd_valid0/1
ram_en  output  1  to RAM ena
ram_we  output  1  to RAM wea
ram_addr  output  ADDR_W  to RAM addra
ram_wr_data  output  DATA_W  to RAM dina
ram_rd_data  input  DATA_W  from RAM douta

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on rising clk.
- Reset values: gnt0/1 = 0, rd_valid0/1 = 0, ram_en = 0, ram_we = 0, ram_addr = 0, ram_wr_data = 0, last_gnt = 1 (so port 0 wins the first tie), state = IDLE.
- FSM, two states:
  - IDLE: sample req0/req1. If none, stay. Otherwise select winner, register its we/addr/wdata onto the ram_* outputs, set ram_en = 1 and the winner's gnt = 1, go to ACCESS.
  - ACCESS: ram_en/gnt high for exactly this cycle. Next state is unconditionally IDLE, with ram_en, ram_we and gnt cleared. ram_addr and ram_wr_data hold their last values.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt high.
  - Requester must deassert req (or present a new request) on the edge ending the gnt cycle.
  - req still high in the following IDLE cycle counts as a new request.
  - Maximum throughput is one access per 2 cycles.
- Arbitration:
  - Only one request pending: that port wins.
  - Both pending: the port not equal to last_gnt wins. last_gnt updates on every grant.
- Reads:
  - A shift pipeline of depth RD_LATENCY carries {valid, port_id} launched in the ACCESS cycle when ram_we = 0.
  - rd_validN pulses for one cycle exactly RD_LATENCY cycles after the ACCESS cycle. rd_data = ram_rd_data (combinational pass-through).
  - Writes produce no rd_valid.
- Ordering: reads return in issue order; no overlap because RD_LATENCY ≤ 3 and the pipeline is independent of the FSM.
- Reset mid-operation: FSM returns to IDLE, read pipeline flushed, and no rd_valid is emitted for in-flight reads. RAM contents are not touched.
- Address wrap is the requesters' responsibility; the arbiter passes addresses unmodified.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Port 0 always wins when both request; last_gnt is unused, and port 1 can starve under continuous port 0 traffic.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5 → gnt0 and ram_en/ram_we high in the same cycle, ram_addr = 3, ram_wr_data = 0xA5. No rd_valid.
- After that write, req1 read addr 3, RD_LATENCY = 1 → gnt1 at cycle T, rd_valid1 at T+1 with rd_data = 0xA5, rd_valid0 stays 0.
- req0 and req1 held high continuously after reset → grant sequence 0,1,0,1, one grant every 2 cycles.
- RD_LATENCY = 2, port 0 reads addr 5 (preloaded 0x3C) → rd_valid0 exactly 2 cycles after gnt0, rd_data = 0x3C.
- Port 0 read granted at T, rst asserted at T+1 → no rd_valid0, all outputs at reset values at T+2. A new request is served normally after rst is released.
- With RAM_ARB_FIXED_PRIO_EN defined, both requesting continuously → gnt0 on every grant, gnt1 never. Dropping req0 → gnt1 on the next grant.
